// File: rtl/clkgate_mc.sv
// clkgate_mc: N independent gated-clock channels, each kept open for HOLD extra
// cycles after its enable drops; SE forces every gated clock open for test.
module clkgate_mc #(
    parameter int N      = 4,
    parameter int HOLD   = 8,
    parameter int HOLD_W = 4
) (
    input  logic         CK,
    input  logic         RST,
    input  logic [N-1:0] E,
    input  logic         SE,
    output logic [N-1:0] GCK,
    output logic [N-1:0] ACT,
    output logic         ALL_OFF
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'b00,
        ST_ON   = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    localparam logic [HOLD_W-1:0] CNT_ZERO = {HOLD_W{1'b0}};
    localparam logic [HOLD_W-1:0] CNT_ONE  = HOLD_W'(32'sd1);
    localparam logic [HOLD_W-1:0] CNT_LOAD = (HOLD > 32'sd0) ? HOLD_W'(HOLD - 32'sd1) : {HOLD_W{1'b0}};

    state_t            state_q [N];
    state_t            state_d [N];
    logic [HOLD_W-1:0] cnt_q   [N];
    logic [HOLD_W-1:0] cnt_d   [N];
    logic [N-1:0]      act_d;
    logic [N-1:0]      act_q;
    logic              all_off_d;
    logic              all_off_q;
    logic [N-1:0]      en_l;

    // Per-channel next-state, hold counter and activity decode.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_OFF: begin
                    if (E[i]) begin
                        state_d[i] = ST_ON;
                    end else begin
                        state_d[i] = ST_OFF;
                    end
                end
                ST_ON: begin
                    if (E[i]) begin
                        state_d[i] = ST_ON;
                    end else if (HOLD > 32'sd0) begin
                        state_d[i] = ST_HOLD;
                        cnt_d[i]   = CNT_LOAD;
                    end else begin
                        state_d[i] = ST_OFF;
                        cnt_d[i]   = CNT_ZERO;
                    end
                end
                ST_HOLD: begin
                    if (E[i]) begin
                        state_d[i] = ST_ON;
                        cnt_d[i]   = CNT_ZERO;
                    end else if (cnt_q[i] == CNT_ZERO) begin
                        state_d[i] = ST_OFF;
                    end else begin
                        state_d[i] = ST_HOLD;
                        cnt_d[i]   = cnt_q[i] - CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = ST_OFF;
                    cnt_d[i]   = CNT_ZERO;
                end
            endcase
            act_d[i] = (state_d[i] != ST_OFF);
        end
        all_off_d = ~|act_d;
    end

    // State, counters and registered status outputs.
    always_ff @(posedge CK) begin
        if (RST) begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= ST_OFF;
                cnt_q[i]   <= CNT_ZERO;
            end
            act_q     <= {N{1'b0}};
            all_off_q <= 1'b1;
        end else begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            act_q     <= act_d;
            all_off_q <= all_off_d;
        end
    end

    // Enable latch: only follows its input while CK is low, so GCK cannot glitch.
    always_latch begin
        if (!CK) begin
            en_l = act_q | {N{SE}};
        end
    end

    assign GCK     = en_l & {N{CK}};
    assign ACT     = act_q;
    assign ALL_OFF = all_off_q;

endmodule

// File: tb/tb_clkgate_mc.sv
// Bench for clkgate_mc: HOLD=3 and HOLD=0 instances side by side, a per-cycle
// scoreboard fed by a reference model, and gated-clock pulse counting.
module tb_clkgate_mc;

    typedef logic [17:0] vec_t;

    logic       CK = 1'b0;
    logic       RST = 1'b1;
    logic       SE = 1'b0;
    logic [3:0] e3 = 4'h0;
    logic [3:0] e0 = 4'h0;
    logic [3:0] gck3, act3, gck0, act0;
    logic       alloff3, alloff0;

    int   checks = 0;
    int   errors = 0;
    vec_t sb_q [$];

    logic [3:0] m_act3 = 4'h0;
    logic [3:0] m_act0 = 4'h0;
    int         m_left3 [4];
    int         m_left0 [4];
    int         pc_obs [8];
    int         pc_exp [8];
    logic [7:0] gck_prev = 8'h00;

    clkgate_mc #(.N(4), .HOLD(3), .HOLD_W(4)) dut (
        .CK(CK), .RST(RST), .E(e3), .SE(SE), .GCK(gck3), .ACT(act3), .ALL_OFF(alloff3)
    );

    clkgate_mc #(.N(4), .HOLD(0), .HOLD_W(4)) dut0 (
        .CK(CK), .RST(RST), .E(e0), .SE(SE), .GCK(gck0), .ACT(act0), .ALL_OFF(alloff0)
    );

    always #5 CK = ~CK;

    // Count rising edges on every gated clock.
    always @(gck3 or gck0) begin
        for (int i = 0; i < 4; i++) begin
            if (gck3[i] === 1'b1 && gck_prev[i] !== 1'b1) pc_obs[i]++;
            if (gck0[i] === 1'b1 && gck_prev[4+i] !== 1'b1) pc_obs[4+i]++;
        end
        gck_prev = {gck0, gck3};
    end

    // Drive one cycle of inputs in the low phase and push the expected outputs
    // seen just after the following rising edge.
    task automatic drive_cycle(input logic [3:0] ev3, input logic [3:0] ev0,
                               input logic se_v, input logic rst_v);
        logic [3:0] g3;
        logic [3:0] g0;
        @(negedge CK);
        e3  = ev3;
        e0  = ev0;
        SE  = se_v;
        RST = rst_v;
        g3  = m_act3 | {4{se_v}};
        g0  = m_act0 | {4{se_v}};
        for (int i = 0; i < 4; i++) begin
            pc_exp[i]   += int'(g3[i]);
            pc_exp[4+i] += int'(g0[i]);
            if (rst_v) begin
                m_act3[i] = 1'b0; m_left3[i] = 0;
                m_act0[i] = 1'b0; m_left0[i] = 0;
            end else begin
                if (ev3[i]) begin
                    m_act3[i] = 1'b1; m_left3[i] = 3;
                end else if (m_left3[i] > 0) begin
                    m_act3[i] = 1'b1; m_left3[i]--;
                end else begin
                    m_act3[i] = 1'b0;
                end
                if (ev0[i]) begin
                    m_act0[i] = 1'b1; m_left0[i] = 0;
                end else if (m_left0[i] > 0) begin
                    m_act0[i] = 1'b1; m_left0[i]--;
                end else begin
                    m_act0[i] = 1'b0;
                end
            end
        end
        sb_q.push_back({g3, m_act3, ~|m_act3, g0, m_act0, ~|m_act0});
    endtask

    task automatic test_reset();
        vec_t exp_v, obs_v;
        for (int c = 0; c < 4; c++) begin
            drive_cycle(4'h0, 4'h0, 1'b0, (c < 2) ? 1'b1 : 1'b0);
            @(posedge CK); #1;
            obs_v = {gck3, act3, alloff3, gck0, act0, alloff0};
            exp_v = sb_q.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL reset_sb c=%0d observed=%h expected=%h", c, obs_v, exp_v);
            end
            checks++;
            if ({gck3, act3, alloff3} !== {4'h0, 4'h0, 1'b1}) begin
                errors++;
                $display("FAIL reset_idle c=%0d observed=%h expected=%h", c, {gck3, act3, alloff3}, {4'h0, 4'h0, 1'b1});
            end
        end
    endtask

    task automatic test_hold_window();
        vec_t exp_v, obs_v;
        int   start;
        start = pc_obs[0];
        for (int c = 0; c < 11; c++) begin
            drive_cycle((c < 5) ? 4'h1 : 4'h0, (c < 5) ? 4'h1 : 4'h0, 1'b0, 1'b0);
            @(posedge CK); #1;
            obs_v = {gck3, act3, alloff3, gck0, act0, alloff0};
            exp_v = sb_q.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL hold_window_sb c=%0d observed=%h expected=%h", c, obs_v, exp_v);
            end
        end
        checks++;
        if (pc_obs[0] - start !== 8) begin
            errors++;
            $display("FAIL hold_window_pulses observed=%0d expected=8", pc_obs[0] - start);
        end
    endtask

    task automatic test_reassert();
        vec_t       exp_v, obs_v;
        logic [9:0] pat;
        pat = 10'b0000011001;
        for (int c = 0; c < 10; c++) begin
            drive_cycle({2'b00, pat[c], 1'b0}, 4'h0, 1'b0, 1'b0);
            @(posedge CK); #1;
            obs_v = {gck3, act3, alloff3, gck0, act0, alloff0};
            exp_v = sb_q.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL reassert_sb c=%0d observed=%h expected=%h", c, obs_v, exp_v);
            end
            if (c >= 1 && c <= 5) begin
                checks++;
                if (gck3[1] !== 1'b1) begin
                    errors++;
                    $display("FAIL reassert_gap c=%0d observed=%b expected=1", c, gck3[1]);
                end
            end
        end
    endtask

    task automatic test_hold0();
        vec_t exp_v, obs_v;
        int   s3, s0;
        s3 = pc_obs[2];
        s0 = pc_obs[6];
        for (int c = 0; c < 7; c++) begin
            drive_cycle((c == 0) ? 4'h4 : 4'h0, (c == 0) ? 4'h4 : 4'h0, 1'b0, 1'b0);
            @(posedge CK); #1;
            obs_v = {gck3, act3, alloff3, gck0, act0, alloff0};
            exp_v = sb_q.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL hold0_sb c=%0d observed=%h expected=%h", c, obs_v, exp_v);
            end
        end
        checks++;
        if (pc_obs[6] - s0 !== 1) begin
            errors++;
            $display("FAIL hold0_pulses observed=%0d expected=1", pc_obs[6] - s0);
        end
        checks++;
        if (pc_obs[2] - s3 !== 4) begin
            errors++;
            $display("FAIL hold3_single_pulses observed=%0d expected=4", pc_obs[2] - s3);
        end
    endtask

    task automatic test_reset_mid();
        vec_t exp_v, obs_v;
        for (int c = 0; c < 11; c++) begin
            drive_cycle((c < 6) ? 4'hF : 4'h0, (c < 6) ? 4'hF : 4'h0, 1'b0,
                        (c == 3 || c == 4) ? 1'b1 : 1'b0);
            @(posedge CK); #1;
            obs_v = {gck3, act3, alloff3, gck0, act0, alloff0};
            exp_v = sb_q.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL reset_mid_sb c=%0d observed=%h expected=%h", c, obs_v, exp_v);
            end
            if (c == 3) begin
                checks++;
                if ({act3, alloff3, gck3} !== {4'h0, 1'b1, 4'hF}) begin
                    errors++;
                    $display("FAIL reset_mid_edge observed=%h expected=%h", {act3, alloff3, gck3}, {4'h0, 1'b1, 4'hF});
                end
            end
            if (c == 4) begin
                checks++;
                if (gck3 !== 4'h0 || gck0 !== 4'h0) begin
                    errors++;
                    $display("FAIL reset_mid_closed observed=%h expected=00", {gck3, gck0});
                end
            end
            if (c == 5) begin
                checks++;
                if (act3 !== 4'hF || alloff3 !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_release observed=%h expected=1e", {act3, alloff3});
                end
            end
        end
    endtask

    task automatic test_scan();
        vec_t exp_v, obs_v;
        for (int c = 0; c < 6; c++) begin
            drive_cycle(4'h0, 4'h0, (c < 5) ? 1'b1 : 1'b0, (c < 2) ? 1'b1 : 1'b0);
            @(posedge CK); #1;
            obs_v = {gck3, act3, alloff3, gck0, act0, alloff0};
            exp_v = sb_q.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL scan_sb c=%0d observed=%h expected=%h", c, obs_v, exp_v);
            end
            checks++;
            if ({gck3, gck0, act3, act0, alloff3} !== {((c < 5) ? 8'hFF : 8'h00), 8'h00, 1'b1}) begin
                errors++;
                $display("FAIL scan_open c=%0d observed=%h expected=%h", c,
                         {gck3, gck0, act3, act0, alloff3}, {((c < 5) ? 8'hFF : 8'h00), 8'h00, 1'b1});
            end
        end
    endtask

    task automatic test_glitch();
        vec_t exp_v, obs_v;
        for (int c = 0; c < 48; c++) begin
            drive_cycle(4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)),
                        ($urandom_range(7, 0) == 0) ? 1'b1 : 1'b0,
                        ($urandom_range(15, 0) == 0) ? 1'b1 : 1'b0);
            @(posedge CK); #1;
            obs_v = {gck3, act3, alloff3, gck0, act0, alloff0};
            exp_v = sb_q.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL glitch_sb c=%0d observed=%h expected=%h", c, obs_v, exp_v);
            end
            #2;
            e3 = ~e3;
            e0 = 4'($urandom_range(15, 0));
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (pc_obs[i] !== pc_exp[i]) begin
                errors++;
                $display("FAIL pulse_count ch=%0d observed=%0d expected=%0d", i, pc_obs[i], pc_exp[i]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            m_left3[i] = 0;
            m_left0[i] = 0;
        end
        test_reset();
        test_hold_window();
        test_reassert();
        test_hold0();
        test_reset_mid();
        test_scan();
        test_glitch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
